normalize_iter: RTL
===================

NORMALIZE_ITER -- requirements
Module: normalize_iter

Interface
REQ-001 SHALL have parameter D_SIZE, default 8, data width; legal values are powers of two >= 4; L = $clog2(D_SIZE).
REQ-002 SHALL have port clk_in, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port valid_in, input, 1, operand valid.
REQ-005 SHALL have port ready_out, output, 1, block can accept an operand.
REQ-006 SHALL have port x_in, input, D_SIZE, operand.
REQ-007 SHALL have port op_in, input, 1, mode select: 0 = logical normalize, 1 = arithmetic normalize.
REQ-008 SHALL have port valid_out, output, 1, result valid.
REQ-009 SHALL have port ready_in, input, 1, consumer accepts the result.
REQ-010 SHALL have port y_out, output, D_SIZE, normalized value.
REQ-011 SHALL have port s_out, output, L, left-shift amount applied to the operand.
REQ-012 SHALL have port zf_out, output, 1, operand had no significant bit.

Function
REQ-013 SHALL implement an FSM with three states, IDLE, RUN and DONE; ready_out = (state == IDLE) and valid_out = (state == DONE).
REQ-014 SHALL, in IDLE when valid_in && ready_out at an edge, capture x_in into working register w, capture op_in, clear count c to 0, set stage index k = L-1 and go to RUN.
REQ-015 SHALL, in RUN, process one stage per clock; at stage k the amount is 2^k.
REQ-016 SHALL, for logical mode, shift when w[D_SIZE-1 -: 2^k] is all zero: w <= w << 2^k (zero fill) and c <= c + 2^k; otherwise w and c are held.
REQ-017 SHALL, for arithmetic mode, shift when w[D_SIZE-1 -: 2^k+1] is all equal (all 0 or all 1): w <= w << 2^k and c <= c + 2^k; otherwise w and c are held.
REQ-018 SHALL decrement k after each RUN stage; after stage k = 0 the FSM goes to DONE, so valid_out rises exactly L cycles after the accepting edge.
REQ-019 SHALL drive y_out = w and s_out = c, and hold them stable while in DONE.
REQ-020 SHALL keep c within L bits without overflow; the maximum value is D_SIZE-1 (sum of all stage amounts).
REQ-021 SHALL compute zf_out as: logical mode, operand == 0; arithmetic mode, operand all zeros or all ones.
REQ-022 SHALL capture zf at the accepting edge and hold it until the result is consumed.
REQ-023 SHALL, in DONE when ready_in = 1, return to IDLE at that edge.
REQ-024 SHALL NOT accept a new operand in the same edge as DONE to IDLE, since ready_out is 0 in DONE; the minimum operand-to-operand interval is L+2 cycles.
REQ-025 SHALL, in DONE when ready_in = 0, stay in DONE with all outputs held indefinitely.
REQ-026 SHALL ignore valid_in, x_in and op_in in RUN and DONE.
REQ-027 SHALL NOT change operand-driven state when valid_in = 0 in IDLE.
REQ-028 SHALL produce a logical-mode result that matches the leading-zero count, with y_out MSB = 1 unless the operand is 0.
REQ-029 SHALL produce an arithmetic-mode result that matches the redundant-sign-bit count, with y_out[D-1] != y_out[D-2] unless zf.

Reset
REQ-030 SHALL, when rst_in = 0 at an edge, force state to IDLE and set w, c, k, zf and the captured op to 0.
REQ-031 SHALL, while in reset, drive ready_out = 0, valid_out = 0, y_out = 0, s_out = 0 and zf_out = 0.
REQ-032 SHALL, on reset asserted in RUN or DONE, abandon the in-flight operation; no valid_out is produced for it.
REQ-033 SHALL, on the first edge with rst_in = 1, sit in IDLE with ready_out = 1.

Verification (D_SIZE = 8, L = 3)
REQ-034 SHALL cover: logical, x=8'h13 accepted -> valid_out 3 cycles later, y=8'h98, s=3, zf=0.
REQ-035 SHALL cover: arithmetic, x=8'hF3 -> y=8'h98, s=3, zf=0; and x=8'hFF -> y=8'h80, s=7, zf=1.
REQ-036 SHALL cover: logical, x=8'h00 -> y=8'h00, s=7, zf=1; and x=8'h80 -> y=8'h80, s=0, zf=0.
REQ-037 SHALL cover: backpressure, ready_in held at 0 for 5 cycles in DONE -> outputs stable, ready_out=0; ready_in=1 -> IDLE next edge; back-to-back valid_in accepted only after IDLE.
REQ-038 SHALL cover: rst_in=0 asserted during RUN stage k=1 -> next edge IDLE, all outputs 0, no valid_out; the next operand is processed correctly.
REQ-039 SHALL cover: random operands in both modes, checked against reference leading-zero and sign-count models, including x_in changing during RUN with no effect.

Source files
------------

// File: rtl/normalize_iter.sv
// Iterative normalizer: a binary-search left shift, one stage per clock, that removes
// leading zeros (logical mode) or redundant sign bits (arithmetic mode) and reports the shift count.
module normalize_iter #(
  parameter int D_SIZE = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [D_SIZE-1:0]          x_in,
  input  logic                       op_in,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [D_SIZE-1:0]          y_out,
  output logic [$clog2(D_SIZE)-1:0]  s_out,
  output logic                       zf_out
);

  localparam int L = $clog2(D_SIZE);
  localparam logic [L-1:0] K_TOP = L'(L-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [D_SIZE-1:0]  w;
  logic [D_SIZE-1:0]  w_sh;
  logic [L-1:0]       c;
  logic [L-1:0]       k;
  logic [L-1:0]       amt;
  logic               op_q;
  logic               zf_q;
  logic               accept;
  logic               shift_en;

  // No significant bit: all zeros, or (arithmetic) nothing but sign.
  function automatic logic zero_flag(input logic [D_SIZE-1:0] x, input logic arith);
    return arith ? ((x == '0) || (x == '1)) : (x == '0);
  endfunction

  // A stage of size n may shift when the top n bits are zero (logical) or the top n+1 bits
  // all equal the sign (arithmetic), so the shift never discards significance.
  function automatic logic can_shift(input logic [D_SIZE-1:0] x, input logic arith, input int n);
    logic zeros;
    logic same;
    zeros = 1'b1;
    same  = 1'b1;
    for (int i = 0; i < D_SIZE; i++) begin
      if (i >= D_SIZE - n)     zeros = zeros & ~x[i];
      if (i >= D_SIZE - n - 1) same  = same & (x[i] == x[D_SIZE-1]);
    end
    return arith ? same : zeros;
  endfunction

  assign accept = (state == IDLE) && valid_in;

  always_comb begin
    amt      = L'(1) << k;
    w_sh     = w << amt;
    shift_en = can_shift(w, op_q, int'(amt));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in) state_nxt = RUN;
      RUN:     if (k == '0)  state_nxt = DONE;
      DONE:    if (ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      w    <= '0;
      c    <= '0;
      k    <= '0;
      op_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (accept) begin
      w    <= x_in;
      c    <= '0;
      k    <= K_TOP;
      op_q <= op_in;
      zf_q <= zero_flag(x_in, op_in);
    end else if (state == RUN) begin
      if (shift_en) begin
        w <= w_sh;
        c <= c + amt;
      end
      k <= k - L'(1);
    end
  end

  // Outputs are forced quiet while reset is held, independent of the registered state.
  assign ready_out = rst_in && (state == IDLE);
  assign valid_out = rst_in && (state == DONE);
  assign y_out     = rst_in ? w : '0;
  assign s_out     = rst_in ? c : '0;
  assign zf_out    = rst_in && zf_q;

endmodule
